// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Build option: define BCD_SATURATE_EN to clamp captured values above 9999 to 9999.
module bin_to_bcd_seq #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] bin_r, bin_s, bin_load_s;
    logic [15:0]      scratch_r, scratch_s, adj_s, shift_s;
    logic [15:0]      bcd_r, bcd_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             ovf_pend_r, ovf_pend_s;
    logic             ovf_r, ovf_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [13:0]      bin_ext_s;
    logic             over_s;

    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    assign bin_ext_s = 14'(bin);
    assign over_s    = (bin_ext_s > 14'd9999);

`ifdef BCD_SATURATE_EN
    assign bin_load_s = over_s ? WIDTH'(14'd9999) : bin;
`else
    assign bin_load_s = bin;
`endif

    assign adj_s   = {add3(scratch_r[15:12]), add3(scratch_r[11:8]),
                      add3(scratch_r[7:4]), add3(scratch_r[3:0])};
    // Thousands carry falls off the top, giving the result modulo 10000.
    assign shift_s = {adj_s[14:0], bin_r[WIDTH-1]};

    // Next-state and datapath update.
    always_comb begin
        state_s    = state_r;
        bin_s      = bin_r;
        scratch_s  = scratch_r;
        cnt_s      = cnt_r;
        ovf_pend_s = ovf_pend_r;
        bcd_s      = bcd_r;
        ovf_s      = ovf_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    bin_s      = bin_load_s;
                    scratch_s  = 16'h0000;
                    cnt_s      = CW'(WIDTH);
                    ovf_pend_s = over_s;
                    state_s    = CONV;
                    busy_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                scratch_s = shift_s;
                bin_s     = {bin_r[WIDTH-2:0], 1'b0};
                cnt_s     = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    bcd_s   = shift_s;
                    ovf_s   = ovf_pend_r;
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            bin_r      <= '0;
            scratch_r  <= 16'h0000;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            bcd_r      <= 16'h0000;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bin_r      <= bin_s;
            scratch_r  <= scratch_s;
            cnt_r      <= cnt_s;
            ovf_pend_r <= ovf_pend_s;
            bcd_r      <= bcd_s;
            ovf_r      <= ovf_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random checks of bin_to_bcd_seq against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] model_bcd;
    logic        model_ovf;

    bin_to_bcd_seq #(.WIDTH(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of the captured value, clamped when saturation is built in.
    function automatic void ref_model(input int v, output logic [15:0] b, output logic o);
        int t;
        o = (v > 9999);
        t = v;
`ifdef BCD_SATURATE_EN
        if (t > 9999) t = 9999;
`endif
        t = t % 10000;
        b = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic conv(input logic [13:0] v, input bit glitch);
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        int          cyc;
        int          bcnt;
        bit          held;
        ref_model(int'(v), exp_bcd, exp_ovf);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
        cyc   = 1;
        bcnt  = 0;
        held  = 1'b1;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            if (bcd !== model_bcd || ovf !== model_ovf) held = 1'b0;
            if (glitch && cyc == 5) begin
                start = 1'b1;
                bin   = 14'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'd15);
        chk("busy_cycles", 32'(bcnt), 32'd14);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("held_before_done", 32'(held), 32'd1);
        chk("bcd", 32'(bcd), 32'(exp_bcd));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        model_bcd = exp_bcd;
        model_ovf = exp_ovf;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("bcd_held_after", 32'(bcd), 32'(model_bcd));
    endtask

    initial begin
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        logic [13:0] a;
        logic [13:0] b;
        logic [13:0] cur;
        int          cnt;
        bit          held;
        bit          seen;

        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd1234;
        model_bcd = 16'h0000;
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0000);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_conv_busy", 32'(busy), 32'd0);
        chk("rst_no_conv_done", 32'(done), 32'd0);

        conv(14'd0, 1'b0);
        conv(14'd1234, 1'b0);
        conv(14'd9999, 1'b0);
        conv(14'd9, 1'b0);
        conv(14'd10, 1'b0);
        conv(14'd12345, 1'b0);
        conv(14'd16383, 1'b0);
        conv(14'd5678, 1'b1);
        conv(14'($urandom_range(0, 16383)), 1'b1);

        // Back-to-back conversions with start held high.
        a = 14'($urandom_range(0, 9999));
        b = 14'($urandom_range(10000, 16383));
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cur = (k % 2 == 0) ? a : b;
            ref_model(int'(cur), exp_bcd, exp_ovf);
            bin = cur;
            @(negedge clk);
            bin  = 14'($urandom);
            cnt  = 1;
            held = 1'b1;
            while (!done && cnt < 40) begin
                if (bcd !== model_bcd || ovf !== model_ovf) held = 1'b0;
                @(negedge clk);
                cnt++;
            end
            chk("b2b_interval", 32'(cnt), 32'd15);
            chk("b2b_held", 32'(held), 32'd1);
            chk("b2b_bcd", 32'(bcd), 32'(exp_bcd));
            chk("b2b_ovf", 32'(ovf), 32'(exp_ovf));
            chk("b2b_busy_at_done", 32'(busy), 32'd0);
            model_bcd = exp_bcd;
            model_ovf = exp_ovf;
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_stop_done", 32'(done), 32'd0);
        chk("b2b_stop_busy", 32'(busy), 32'd0);

        // Abort on the 7th conversion cycle.
        start = 1'b1;
        bin   = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (cnt < 7) begin
            @(negedge clk);
            cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_bcd = 16'h0000;
        model_ovf = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'h0000);
        chk("abort_ovf", 32'(ovf), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        conv(14'd4321, 1'b0);

        for (int i = 0; i < 10; i++) begin
            conv(14'($urandom_range(0, 16383)), 1'(i % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3) that sits directly upstream of the four-digit seven-segment display multiplexer. It converts an unsigned binary count into four packed BCD digits and holds them stable, so the display stage can sample them at its own refresh rate. The converter is iterative, one bit per clock, and uses a start/busy/done handshake.

## Interface
- WIDTH, 14: binary input width, legal range 4..14.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of `bin`; sampled only in IDLE or DONE.
- bin  in  WIDTH  unsigned value to convert; captured on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; `bcd` and `ovf` are updated on the same edge.
- bcd  out  16  packed result: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- ovf  out  1  captured `bin` exceeded 9999; valid with `bcd`.

## Operation
- States: IDLE, CONV, DONE.
- IDLE/DONE with start=1:
  - Load the `bin` shift register.
  - Clear the 16-bit BCD scratch.
  - Set bit counter = WIDTH.
  - Register ovf_pending = (bin > 9999).
  - Go to CONV.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- CONV, each cycle:
  - Add 3 to every scratch digit that is ≥5.
  - Shift {scratch, binreg} left by one.
  - Decrement the counter.
  - When the counter reaches 1 on this edge: copy the post-shift scratch to `bcd`, copy ovf_pending to `ovf`, and go to DONE.
- `start` in CONV is ignored. `bin` changes after capture do not affect the result.
- The carry out of the thousands digit is discarded, so the result is (captured value mod 10000).
- `bcd`/`ovf` hold their last result until the next completion. They never show partial values.
- Only WIDTH=14 can produce ovf=1, since 2^13−1 < 10000.

## Timing
- Reset values: state=IDLE, busy=0, done=0, bcd=16'h0000, ovf=0, counter=0.
- Start accepted at edge E0. busy=1 for cycles after edges E0..E(WIDTH−1), i.e. exactly WIDTH cycles.
- On edge E(WIDTH): `bcd`/`ovf` update, busy→0, done→1 for one cycle.
- Latency: WIDTH+1 edges from accepting edge to done pulse (15 for WIDTH=14).
- busy and done are never high together.
- start held high continuously: a new conversion is accepted in the DONE cycle. Throughput is one result per WIDTH+1 cycles.
- rst mid-conversion: aborts on that edge and all outputs return to reset values. rst has priority over start.
- `bcd` is fully registered, so the display may sample it asynchronously to `done` without seeing glitches.

## Configuration
- BCD_SATURATE_EN defined:
  - On capture, any bin > 9999 is replaced by 9999 before conversion.
  - Result is bcd=16'h9999 with ovf=1.
- BCD_SATURATE_EN undefined:
  - No clamping; result is bin mod 10000 with ovf=1 (e.g. 12345 → 16'h2345).
- Handshake, latency and all other behaviour are identical in both builds.

## Test plan
- Reset: assert rst for 2 cycles with start=1 and bin=1234 → busy=0, done=0, bcd=16'h0000, ovf=0 after release, and no conversion started.
- Zero and nominal values: bin=0 then bin=1234, one start pulse each → done exactly 15 edges after acceptance, busy high 14 cycles, bcd=16'h0000 then 16'h1234, ovf=0.
- Boundary values: bin=9999 → 16'h9999, ovf=0. bin=9 → 16'h0009. bin=10 → 16'h0010.
- Overflow: bin=12345 → ovf=1. bcd=16'h9999 with BCD_SATURATE_EN defined, 16'h2345 without. bin=16383 → 16'h9999 / 16'h6383.
- Handshake edges:
  - start pulsed and bin changed mid-CONV → ignored, and the result reflects the originally captured value.
  - start held high with alternating bin values → back-to-back results every 15 cycles, previous bcd held between done pulses.
- Abort: rst asserted on the 7th CONV cycle of bin=4321 → next cycle busy=0, bcd=16'h0000, and no done pulse. A following start with bin=4321 yields 16'h4321.
